// File: rtl/othello_pkg.sv
// Shared definitions for the board front-end: button indices, default
// conditioning timings and the auto-repeat state encoding.
package othello_pkg;

    localparam int BTN_EAST  = 0;
    localparam int BTN_WEST  = 1;
    localparam int BTN_NORTH = 2;
    localparam int BTN_SOUTH = 3;
    localparam int BTN_KNOB  = 4;
    localparam int NUM_BTN   = 5;

    // Defaults assume a 50 MHz clock: 10 ms debounce, 0.5 s first repeat, 0.2 s repeat rate.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;
    localparam logic [NUM_BTN-1:0] DEF_REPEAT_MASK = 5'b01111;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for a modulus, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, counter debounce, press edge pulse
// and an optional hold-to-repeat generator.
module btn_debounce
    import othello_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse,
    output logic o_pulse_next
);

    localparam int CNT_W  = clog2_min1(DEBOUNCE_CYCLES);
    localparam int RCNT_W = clog2_min1(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DLY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PER_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_lvl;
    logic              r_lvl_d;
    logic [CNT_W-1:0]  r_cnt;
    rpt_state_t        r_state;
    logic [RCNT_W-1:0] r_rcnt;
    logic              r_pulse;

    logic w_rise;
    logic w_rep_fire;
    logic w_pulse_next;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Any single cycle of agreement with the stable level restarts the count.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_lvl_d <= r_lvl;
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_lvl <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_rise     = r_lvl & ~r_lvl_d;
    assign w_rep_fire = REPEAT_EN && r_lvl &&
                        (((r_state == RPT_DELAY)  && (r_rcnt == DLY_LAST)) ||
                         ((r_state == RPT_REPEAT) && (r_rcnt == PER_LAST)));
    assign w_pulse_next = w_rise | w_rep_fire;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RPT_IDLE;
            r_rcnt  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_pulse_next;
            if (!REPEAT_EN || !r_lvl) begin
                r_state <= RPT_IDLE;
                r_rcnt  <= '0;
            end else begin
                case (r_state)
                    RPT_IDLE: begin
                        if (w_rise) begin
                            r_state <= RPT_DELAY;
                            r_rcnt  <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (r_rcnt == DLY_LAST) begin
                            r_state <= RPT_REPEAT;
                            r_rcnt  <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + RCNT_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (r_rcnt == PER_LAST) begin
                            r_rcnt <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + RCNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= RPT_IDLE;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level      = r_lvl;
    assign o_pulse      = r_pulse;
    assign o_pulse_next = w_pulse_next;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the five raw board inputs into stable levels plus press and
// auto-repeat pulses for the cursor stage.
module btn_conditioner
    import othello_pkg::*;
#(
    parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int                 REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int                 REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = DEF_REPEAT_MASK
) (
    input  logic               clk,
    input  logic               RST_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               btn_any
);

    logic [NUM_BTN-1:0] w_pulse_next;
    logic               r_any;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[g])
        ) u_ch (
            .clk          (clk),
            .i_rst_n      (RST_n),
            .i_raw        (btn_raw[g]),
            .o_level      (btn_level[g]),
            .o_pulse      (btn_pulse[g]),
            .o_pulse_next (w_pulse_next[g])
        );
    end

    // Built from the per-channel next-pulse terms so it lands on the same edge as btn_pulse.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_pulse_next;
        end
    end

    assign btn_any = r_any;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timings (debounce 4, delay 20, period 8).
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       RST_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic       btn_any;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .REPEAT_MASK     (5'b01111)
    ) dut (
        .clk       (clk),
        .RST_n     (RST_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .btn_any   (btn_any)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns on the falling edge just after one rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int np;
        logic ep;

        RST_n   = 1'b0;
        btn_raw = 5'b0;
        #2;
        chk("rst_level", btn_level, 5'b0);
        chk("rst_pulse", btn_pulse, 5'b0);
        chk("rst_any", btn_any, 1'b0);
        @(negedge clk);
        idle(2);
        RST_n = 1'b1;
        idle(3);
        chk("idle_level", btn_level, 5'b0);

        // Clean press on east: first sampled at edge 0.
        btn_raw[0] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk($sformatf("press_lvl_e%0d", e), btn_level, (e >= 5) ? 5'b00001 : 5'b0);
            chk($sformatf("press_pls_e%0d", e), btn_pulse, (e == 6) ? 5'b00001 : 5'b0);
            chk($sformatf("press_any_e%0d", e), btn_any, (e == 6));
        end
        btn_raw[0] = 1'b0;
        idle(12);
        chk("press_release_lvl", btn_level, 5'b0);

        // North bounces every 2 cycles for 20 cycles, then settles high, then released.
        np = 0;
        for (int e = 0; e < 48; e++) begin
            if (e < 20)      btn_raw[2] = ((e % 4) < 2);
            else if (e < 36) btn_raw[2] = 1'b1;
            else             btn_raw[2] = 1'b0;
            tick();
            if (btn_pulse[2]) np++;
            if (e == 24) chk("bounce_lvl_e24", btn_level[2], 1'b0);
            if (e == 25) chk("bounce_lvl_e25", btn_level[2], 1'b1);
            if (e == 26) chk("bounce_pls_e26", btn_pulse[2], 1'b1);
        end
        chk("bounce_npulse", np, 1);
        chk("bounce_end_lvl", btn_level, 5'b0);

        // Three-cycle glitch on west must be rejected.
        for (int e = 0; e < 15; e++) begin
            btn_raw[1] = (e < 3);
            tick();
            chk($sformatf("glitch_e%0d", e), {btn_level[1], btn_pulse[1]}, 2'b00);
        end

        // North held: press pulse then repeats; raw drops before edge 59.
        np = 0;
        for (int e = 0; e < 80; e++) begin
            btn_raw[2] = (e < 59);
            tick();
            ep = (e == 6) || (e == 26) || (e == 34) || (e == 42) || (e == 50) || (e == 58);
            chk($sformatf("rpt_pls_e%0d", e), btn_pulse[2], ep);
            chk($sformatf("rpt_any_e%0d", e), btn_any, ep);
            if (btn_pulse[2]) np++;
            if (e == 63) chk("rpt_lvl_e63", btn_level[2], 1'b1);
            if (e == 64) chk("rpt_lvl_e64", btn_level[2], 1'b0);
        end
        chk("rpt_npulse", np, 6);

        // Input bit 4 held 60 cycles never repeats.
        np = 0;
        for (int e = 0; e < 75; e++) begin
            btn_raw[4] = (e < 60);
            tick();
            if (btn_pulse[4]) np++;
            if (e == 6) chk("knob_pls_e6", btn_pulse[4], 1'b1);
            if (e == 40) chk("knob_lvl_e40", btn_level, 5'b10000);
        end
        chk("knob_npulse", np, 1);
        chk("knob_end_lvl", btn_level, 5'b0);

        // East and north pressed on the same edge.
        np = 0;
        btn_raw[0] = 1'b1;
        btn_raw[2] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk($sformatf("simul_pls_e%0d", e), btn_pulse, (e == 6) ? 5'b00101 : 5'b0);
            if (btn_any) np++;
        end
        chk("simul_any_count", np, 1);
        btn_raw[0] = 1'b0;
        btn_raw[2] = 1'b0;
        idle(12);
        chk("simul_end_lvl", btn_level, 5'b0);

        // South held; async reset mid-hold, released with button still held.
        btn_raw[3] = 1'b1;
        idle(10);
        chk("areset_pre_lvl", btn_level, 5'b01000);
        #2;
        RST_n = 1'b0;
        #1;
        chk("areset_lvl", btn_level, 5'b0);
        chk("areset_pls", btn_pulse, 5'b0);
        chk("areset_any", btn_any, 1'b0);
        @(negedge clk);
        chk("areset_hold_lvl", btn_level, 5'b0);
        RST_n = 1'b1;
        for (int e = 0; e < 14; e++) begin
            tick();
            chk($sformatf("arel_pls_e%0d", e), btn_pulse, (e == 6) ? 5'b01000 : 5'b0);
            chk($sformatf("arel_lvl_e%0d", e), btn_level, (e >= 5) ? 5'b01000 : 5'b0);
        end
        btn_raw[3] = 1'b0;
        idle(12);
        chk("arel_end_lvl", btn_level, 5'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
